// File: rtl/sip_pkg.sv
// Shared definitions for the SipHash round engine: word width, FSM states,
// rotation amounts, the packed four-word state and a rotate-left helper.
package sip_pkg;

    localparam int WORD_W = 64;

    // Rotation amounts used by one SipRound, in order of appearance.
    localparam int ROT_13 = 13;
    localparam int ROT_16 = 16;
    localparam int ROT_21 = 21;
    localparam int ROT_17 = 17;
    localparam int ROT_32 = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] v0;
        logic [WORD_W-1:0] v1;
        logic [WORD_W-1:0] v2;
        logic [WORD_W-1:0] v3;
    } sip_state_t;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int r);
        return (x << r) | (x >> (WORD_W - r));
    endfunction

endpackage

// File: rtl/sip_round.sv
// One combinational SipRound: four ARX half-steps over v0..v3.
module sip_round
    import sip_pkg::*;
(
    input  sip_state_t cur,
    output sip_state_t nxt
);

    logic [WORD_W-1:0] a0, b1, c0, a2, b3, d0, e3, f2, g1, h2;

    // Step 1: v0+=v1; v1=rotl(v1,13)^v0; v0=rotl(v0,32)
    assign a0 = cur.v0 + cur.v1;
    assign b1 = rotl(cur.v1, ROT_13) ^ a0;
    assign c0 = rotl(a0, ROT_32);
    // Step 2: v2+=v3; v3=rotl(v3,16)^v2
    assign a2 = cur.v2 + cur.v3;
    assign b3 = rotl(cur.v3, ROT_16) ^ a2;
    // Step 3: v0+=v3; v3=rotl(v3,21)^v0
    assign d0 = c0 + b3;
    assign e3 = rotl(b3, ROT_21) ^ d0;
    // Step 4: v2+=v1; v1=rotl(v1,17)^v2; v2=rotl(v2,32)
    assign f2 = a2 + b1;
    assign g1 = rotl(b1, ROT_17) ^ f2;
    assign h2 = rotl(f2, ROT_32);

    assign nxt = '{v0: d0, v1: g1, v2: h2, v3: e3};

endmodule

// File: rtl/sip_round_engine.sv
// Iterative SipRound engine: applies a runtime number of SipRounds to a
// 256-bit state, UNROLL rounds per cycle, with valid/ready on both sides.
// Optional feature: define SIP_ROUND_ENGINE_ABORT_EN to add the abort input,
// which cancels an in-flight request or held result.
module sip_round_engine
    import sip_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CNT_W-1:0]  in_rounds,
    input  logic [WORD_W-1:0] iv0,
    input  logic [WORD_W-1:0] iv1,
    input  logic [WORD_W-1:0] iv2,
    input  logic [WORD_W-1:0] iv3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] ov0,
    output logic [WORD_W-1:0] ov1,
    output logic [WORD_W-1:0] ov2,
    output logic [WORD_W-1:0] ov3,
    output logic              busy
`ifdef SIP_ROUND_ENGINE_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam logic [CNT_W-1:0] UNR = CNT_W'(UNROLL);

    state_t           state, state_n;
    sip_state_t       st, st_n, round_out;
    logic [CNT_W-1:0] remaining, remaining_n, n;
    logic             accept, abort_i;
    sip_state_t       stage_out [UNROLL];

`ifdef SIP_ROUND_ENGINE_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Chain of UNROLL round stages fed from the state registers.
    for (genvar g = 0; g < UNROLL; g++) begin : g_stage
        sip_state_t s_in, s_out;
        if (g == 0) begin : g_first
            assign s_in = st;
        end else begin : g_next
            assign s_in = g_stage[g-1].s_out;
        end
        sip_round u_round (.cur(s_in), .nxt(s_out));
        assign stage_out[g] = s_out;
    end

    assign n = (remaining > UNR) ? UNR : remaining;

    // Pick the output of stage n so a short final batch stops early.
    always_comb begin
        round_out = st;
        for (int i = 0; i < UNROLL; i++) begin
            if (n == CNT_W'(i + 1)) round_out = stage_out[i];
        end
    end

    assign in_ready  = ((state == IDLE) | ((state == DONE) & out_ready)) & ~abort_i;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign {ov0, ov1, ov2, ov3} = st;

    // Next-state logic: load on accept, advance in RUN, release in DONE.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n     = state;
        st_n        = st;
        remaining_n = remaining;
        if (abort_i && state != IDLE) begin
            state_n = IDLE;
        end else if (accept) begin
            st_n        = '{v0: iv0, v1: iv1, v2: iv2, v3: iv3};
            remaining_n = in_rounds;
            state_n     = (in_rounds == '0) ? DONE : RUN;
        end else begin
            unique case (state)
                RUN: begin
                    st_n        = round_out;
                    remaining_n = remaining - n;
                    if (remaining_n == '0) state_n = DONE;
                end
                DONE: begin
                    if (out_ready) state_n = IDLE;
                end
                default: ;
            endcase
        end
    end

    // State, round counter and state-word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            st        <= '0;
            remaining <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // pre-edge values regardless of statement order.
            state     <= state_n;
            st        <= st_n;
            remaining <= remaining_n;
        end
    end

endmodule

// File: doc/sip_round_engine.md
# sip_round_engine

Iterative, parametrised SipRound engine. Accepts a 256-bit SipHash state (v0..v3) and a runtime round count, and applies that many SipRounds over several clock cycles, with UNROLL rounds per cycle. It returns the final state through a valid/ready handshake. It sits between the SipHash message/finalisation sequencer and the state registers, and serves both the c compression rounds and the d finalisation rounds of SipHash-c-d.

## Interface

Parameters:
- UNROLL, 1, SipRounds applied per RUN cycle; legal values 1, 2, 4.
- CNT_W, 4, width of the round-count input; maximum rounds per request is 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  request present.
- in_ready  output  1  engine can accept a request this cycle.
- in_rounds  input  CNT_W  number of SipRounds to apply; 0 is legal.
- iv0, iv1, iv2, iv3  input  64 each  input state words.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result.
- ov0, ov1, ov2, ov3  output  64 each  result state words.
- busy  output  1  high in the RUN state.
- abort  input  1  cancels the in-flight request; present only with SIP_ROUND_ENGINE_ABORT_EN.

## Operation

- States:
  - IDLE: reset state.
  - RUN: rounds are being applied.
  - DONE: result is held on the outputs.
- State registers: v0..v3, and remaining (CNT_W bits).
- Accept condition: in_valid & in_ready.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - With abort compiled in, in_ready is forced to 0 while abort=1.
- On accept: load iv0..iv3 and remaining=in_rounds.
  - If in_rounds==0, go to DONE; the output equals the input.
  - Otherwise go to RUN.
- RUN, each cycle:
  - Apply n = min(UNROLL, remaining) rounds.
  - Do this by chaining UNROLL round stages and selecting stage n's output.
  - Set remaining -= n.
  - When remaining reaches 0, go to DONE.
- DONE:
  - out_valid=1; ov0..ov3 = state registers, held stable until out_ready=1.
  - out_ready=1 with no new accept: go to IDLE.
  - out_ready=1 with a simultaneous accept: back-to-back; load the new request per the accept rules.
- SipRound arithmetic: all additions are mod 2^64, with no carry out; rotations are left rotations of 64-bit words. The steps in order:
  1. v0+=v1; v1=rotl(v1,13); v1^=v0; v0=rotl(v0,32)
  2. v2+=v3; v3=rotl(v3,16); v3^=v2
  3. v0+=v3; v3=rotl(v3,21); v3^=v0
  4. v2+=v1; v1=rotl(v1,17); v1^=v2; v2=rotl(v2,32)
- in_valid while not ready: ignored. The requester must hold the request until accepted.
- Reset mid-operation: immediately returns to IDLE; the partial result is lost.

## Timing

- Reset values:
  - state=IDLE; out_valid=0; busy=0; remaining=0.
  - ov0..ov3 = 0 (registers cleared).
  - in_ready=1, because it is combinational from IDLE.
- Latency: accept edge to first cycle with out_valid=1.
  - 1 cycle when in_rounds=0.
  - ceil(in_rounds/UNROLL)+1 cycles otherwise.
  - Example: UNROLL=1 and 4 rounds gives 5 cycles.
- Throughput: one result per ceil(R/UNROLL)+1 cycles, when out_ready is held high.
- busy is registered: high exactly during RUN cycles.

## Configuration

- SIP_ROUND_ENGINE_ABORT_EN defined:
  - abort port exists.
  - abort=1 in RUN or DONE: go to IDLE at the next edge; out_valid and busy fall; the result is discarded.
  - abort wins over a simultaneous accept and over out_ready.
  - abort in IDLE: no effect, other than forcing in_ready=0 in that cycle.
- Not defined:
  - No abort port.
  - Every accepted request runs to completion.

## Structure

- Shared package sip_pkg holds:
  - the 64-bit word width localparam;
  - the state enum (IDLE, RUN, DONE);
  - the rotation constants 13, 16, 21, 17, 32.
- One sub-module: the existing combinational sip_round, instantiated UNROLL times in a chain, with a stage-select mux on the chain outputs.
- No further sub-modules.

## Test plan

- All-zero state, in_rounds=4, UNROLL=1 -> out_valid exactly 5 cycles after accept, with ov0..ov3 = 0.
- iv1=1 and other words 0, in_rounds=1 -> ov0=0x0000000100000000, ov1=0x0000000040022001, ov2=0x0000200100000000, ov3=0x0000000100000000.
- in_rounds=0 with arbitrary state -> outputs equal the inputs one cycle after accept; busy never asserts.
- UNROLL=2, in_rounds=3 -> 3 cycles of latency; result identical to UNROLL=1 with 3 rounds.
- out_ready held low for 10 cycles in DONE, then pulsed together with a new in_valid -> outputs stable for all 10 cycles, and the new request is accepted on the same edge with no idle cycle.
- With ABORT_EN: abort in the 2nd RUN cycle -> IDLE at the next edge with out_valid=0. Then apply reset mid-RUN -> all outputs return to reset values asynchronously.
